btn_event_arbiter: RTL

//  Front-end controller for the board push-buttons. Per button: synchronises, debounces and

---
 rtl/btn_event_arbiter_if.sv | 12 +
 rtl/btn_event_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/btn_event_arbiter_if.sv
// Event handshake between the button front-end (master) and the display controller (slave).
interface btn_event_arbiter_if #(
    parameter int ID_W = 2
);
    logic            evt_valid;
    logic            evt_ready;
    logic [ID_W-1:0] evt_id;
    logic            evt_drop;

    modport master (output evt_valid, output evt_id, output evt_drop, input evt_ready);
    modport slave  (input evt_valid, input evt_id, input evt_drop, output evt_ready);
endinterface

// File: rtl/btn_event_arbiter.sv
// Push-button front end: per-button sync/debounce/edge lanes, round-robin arbiter, event FIFO.
// Optional auto-repeat on held buttons is built only when AUTO_REPEAT_EN is defined.
module btn_event_lane #(
    parameter int DEBOUNCE_CNT  = 1000000,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic set_req
);
    localparam int DB_W = $clog2(DEBOUNCE_CNT);

    logic            s0_q, s0_d, s1_q, s1_d;
    logic            stable_q, stable_d, stable_prev_q, stable_prev_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            rise, rpt_req;

    always_comb begin
        s0_d          = btn_in;
        s1_d          = s0_q;
        stable_prev_d = stable_q;
        stable_d      = stable_q;
        db_cnt_d      = '0;
        if (s1_q != stable_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CNT - 1)) stable_d = s1_q;
            else                                     db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    assign rise    = stable_q & ~stable_prev_q;
    assign set_req = rise | rpt_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_q          <= 1'b0;
            s1_q          <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            db_cnt_q      <= '0;
        end else begin
            s0_q          <= s0_d;
            s1_q          <= s1_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            db_cnt_q      <= db_cnt_d;
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    logic             rpt_act_q, rpt_act_d, rpt_first_q, rpt_first_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;

    // First interval is REPEAT_DELAY from the rise, later ones REPEAT_PERIOD.
    always_comb begin
        rpt_req     = rpt_act_q & stable_q &
                      (rpt_cnt_q == (rpt_first_q ? RPT_W'(REPEAT_DELAY - 1)
                                                 : RPT_W'(REPEAT_PERIOD - 1)));
        rpt_act_d   = rpt_act_q;
        rpt_first_d = rpt_first_q;
        rpt_cnt_d   = rpt_cnt_q;
        if (rise) begin
            rpt_act_d   = 1'b1;
            rpt_first_d = 1'b1;
            rpt_cnt_d   = '0;
        end else if (!stable_q) begin
            rpt_act_d = 1'b0;
            rpt_cnt_d = '0;
        end else if (rpt_act_q) begin
            if (rpt_req) begin
                rpt_cnt_d   = '0;
                rpt_first_d = 1'b0;
            end else begin
                rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_act_q   <= 1'b0;
            rpt_first_q <= 1'b0;
            rpt_cnt_q   <= '0;
        end else begin
            rpt_act_q   <= rpt_act_d;
            rpt_first_q <= rpt_first_d;
            rpt_cnt_q   <= rpt_cnt_d;
        end
    end
`else
    assign rpt_req = (REPEAT_DELAY < 0) && (REPEAT_PERIOD < 0);
`endif
endmodule

module btn_event_arbiter #(
    parameter int N_BTN         = 4,
    parameter int DEBOUNCE_CNT  = 1000000,
    parameter int FIFO_DEPTH    = 4,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_BTN-1:0]       btn_in,
    btn_event_arbiter_if.master    evt
);
    localparam int ID_W  = $clog2(N_BTN);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [N_BTN-1:0]                 set_req, gnt, pend_q, pend_d;
    logic [ID_W-1:0]                  rr_ptr_q, rr_ptr_d, gnt_id, idx;
    logic                             gnt_vld, drop, push, pop;
    logic [FIFO_DEPTH-1:0][ID_W-1:0]  mem_q, mem_d;
    logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]                 count_q, count_d;

    for (genvar i = 0; i < N_BTN; i++) begin : g_lane
        btn_event_lane #(
            .DEBOUNCE_CNT (DEBOUNCE_CNT),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_in (btn_in[i]),
            .set_req(set_req[i])
        );
    end

    // Round-robin search from rr_ptr; full FIFO blocks grants even if a pop is under way.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        if (count_q < CNT_W'(FIFO_DEPTH)) begin
            for (int k = 0; k < N_BTN; k++) begin
                idx = ID_W'((int'(rr_ptr_q) + k) % N_BTN);
                if (!gnt_vld && pend_q[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = idx;
                end
            end
        end
        if (gnt_vld) gnt[gnt_id] = 1'b1;
        pend_d   = (pend_q & ~gnt) | set_req;
        drop     = |(set_req & pend_q & ~gnt);
        rr_ptr_d = rr_ptr_q;
        if (gnt_vld) rr_ptr_d = (gnt_id == ID_W'(N_BTN - 1)) ? '0 : gnt_id + ID_W'(1);
    end

    assign push = gnt_vld;
    assign pop  = (count_q != '0) & evt.evt_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = gnt_id;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q   <= '0;
            rr_ptr_q <= '0;
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pend_q   <= pend_d;
            rr_ptr_q <= rr_ptr_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign evt.evt_valid = (count_q != '0);
    assign evt.evt_id    = mem_q[rd_ptr_q];
    assign evt.evt_drop  = drop;
endmodule
